// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU: a single issue stage
// (S1) fed by a round-robin or fixed-priority arbiter, plus one result buffer per requester.

`ifndef XLEN
`define XLEN 64
`endif
`ifndef ALUOP_LEN
`define ALUOP_LEN 4
`endif

module alu_arbiter #(
   parameter int RR_EN = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush_i,

   input  logic                  r0_valid_i,
   output logic                  r0_ready_o,
   input  logic [`XLEN-1:0]      r0_a_i,
   input  logic [`XLEN-1:0]      r0_b_i,
   input  logic [`ALUOP_LEN-1:0] r0_op_i,
   input  logic [3:0]            r0_tag_i,
   output logic                  r0_res_valid_o,
   input  logic                  r0_res_ready_i,
   output logic [`XLEN-1:0]      r0_res_o,
   output logic                  r0_cmp_o,
   output logic [3:0]            r0_tag_o,

   input  logic                  r1_valid_i,
   output logic                  r1_ready_o,
   input  logic [`XLEN-1:0]      r1_a_i,
   input  logic [`XLEN-1:0]      r1_b_i,
   input  logic [`ALUOP_LEN-1:0] r1_op_i,
   input  logic [3:0]            r1_tag_i,
   output logic                  r1_res_valid_o,
   input  logic                  r1_res_ready_i,
   output logic [`XLEN-1:0]      r1_res_o,
   output logic                  r1_cmp_o,
   output logic [3:0]            r1_tag_o,

   output logic [`XLEN-1:0]      alu_a_o,
   output logic [`XLEN-1:0]      alu_b_o,
   output logic [`ALUOP_LEN-1:0] alu_op_o,
   input  logic [`XLEN-1:0]      alu_out_i,
   input  logic                  alu_cmp_i,

   output logic [31:0]           conflict_cnt_o
);

   logic [1:0]            req_valid;
   logic [1:0]            res_ready;
   logic [1:0]            pop;
   logic [1:0]            rb_load;
   logic                  grant;
   logic                  drain;
   logic                  can_accept;
   logic                  accept;

   logic                  s1_valid;
   logic                  s1_owner;
   logic [`XLEN-1:0]      s1_a;
   logic [`XLEN-1:0]      s1_b;
   logic [`ALUOP_LEN-1:0] s1_op;
   logic [3:0]            s1_tag;

   logic [1:0]            rb_valid;
   logic [1:0]            rb_cmp;
   logic [`XLEN-1:0]      rb_res [2];
   logic [3:0]            rb_tag [2];

   logic                  last_grant;
   logic [31:0]           conflict_cnt;

   logic [`XLEN-1:0]      sel_a;
   logic [`XLEN-1:0]      sel_b;
   logic [`ALUOP_LEN-1:0] sel_op;
   logic [3:0]            sel_tag;

   assign req_valid  = {r1_valid_i, r0_valid_i};
   assign res_ready  = {r1_res_ready_i, r0_res_ready_i};
   assign pop        = rb_valid & res_ready;
   assign drain      = s1_valid & (~rb_valid[s1_owner] | pop[s1_owner]);
   // rst gates acceptance so no ready is shown while the block is held in reset
   assign can_accept = (~s1_valid | drain) & ~flush_i & ~rst;
   assign rb_load    = {drain & s1_owner, drain & ~s1_owner};

   always_comb begin
      grant = 1'b0;
      case (req_valid)
         2'b10:   grant = 1'b1;
         2'b11:   grant = (RR_EN != 0) ? ~last_grant : 1'b0;
         default: grant = 1'b0;
      endcase
   end

   assign r0_ready_o = can_accept & r0_valid_i & ~grant;
   assign r1_ready_o = can_accept & r1_valid_i & grant;
   assign accept     = r0_ready_o | r1_ready_o;

   always_comb begin
      sel_a   = r0_a_i;
      sel_b   = r0_b_i;
      sel_op  = r0_op_i;
      sel_tag = r0_tag_i;
      if (grant) begin
         sel_a   = r1_a_i;
         sel_b   = r1_b_i;
         sel_op  = r1_op_i;
         sel_tag = r1_tag_i;
      end
   end

   // Issue stage: a new accept may overwrite S1 in the same cycle it drains
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_owner <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_op    <= '0;
         s1_tag   <= '0;
      end else if (flush_i) begin
         s1_valid <= 1'b0;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_owner <= grant;
         s1_a     <= sel_a;
         s1_b     <= sel_b;
         s1_op    <= sel_op;
         s1_tag   <= sel_tag;
      end else if (drain) begin
         s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rb_valid  <= '0;
         rb_cmp    <= '0;
         rb_res[0] <= '0;
         rb_res[1] <= '0;
         rb_tag[0] <= '0;
         rb_tag[1] <= '0;
      end else begin
         if (flush_i) begin
            rb_valid <= '0;
         end else begin
            rb_valid <= (rb_valid & ~pop) | rb_load;
         end
         if (rb_load[0]) begin
            rb_res[0] <= alu_out_i;
            rb_cmp[0] <= alu_cmp_i;
            rb_tag[0] <= s1_tag;
         end
         if (rb_load[1]) begin
            rb_res[1] <= alu_out_i;
            rb_cmp[1] <= alu_cmp_i;
            rb_tag[1] <= s1_tag;
         end
      end
   end

   // last_grant resets to 1 so that requester 0 wins the first conflict
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= 1'b1;
      end else if (accept) begin
         last_grant <= grant;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         conflict_cnt <= '0;
      end else if (r0_valid_i && r1_valid_i && (conflict_cnt != 32'hFFFF_FFFF)) begin
         conflict_cnt <= conflict_cnt + 32'd1;
      end
   end

   assign alu_a_o        = s1_valid ? s1_a  : '0;
   assign alu_b_o        = s1_valid ? s1_b  : '0;
   assign alu_op_o       = s1_valid ? s1_op : '0;

   assign r0_res_valid_o = rb_valid[0];
   assign r0_res_o       = rb_res[0];
   assign r0_cmp_o       = rb_cmp[0];
   assign r0_tag_o       = rb_tag[0];
   assign r1_res_valid_o = rb_valid[1];
   assign r1_res_o       = rb_res[1];
   assign r1_cmp_o       = rb_cmp[1];
   assign r1_tag_o       = rb_tag[1];

   assign conflict_cnt_o = conflict_cnt;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a round-robin and a fixed-priority instance share stimulus and
// are checked each cycle against a transaction-level model plus directed literal scenarios.

`ifndef XLEN
`define XLEN 64
`endif
`ifndef ALUOP_LEN
`define ALUOP_LEN 4
`endif

module tb_alu_arbiter;

   localparam int XL  = `XLEN;
   localparam int OPW = `ALUOP_LEN;

   localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
   localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
   localparam logic [OPW-1:0] OP_BLT  = OPW'(2);
   localparam logic [OPW-1:0] OP_BLTU = OPW'(3);
   localparam logic [OPW-1:0] OP_AND  = OPW'(4);
   localparam logic [OPW-1:0] OP_OR   = OPW'(5);
   localparam logic [OPW-1:0] OP_XOR  = OPW'(6);

   logic           clk;
   logic           rst;
   logic           flush;
   logic           vld  [2];
   logic [XL-1:0]  opa  [2];
   logic [XL-1:0]  opb  [2];
   logic [OPW-1:0] opc  [2];
   logic [3:0]     tgi  [2];
   logic           rrdy [2];

   logic           rdy  [2][2];
   logic           rvld [2][2];
   logic [XL-1:0]  res  [2][2];
   logic           cmpo [2][2];
   logic [3:0]     tgo  [2][2];
   logic [XL-1:0]  alu_a   [2];
   logic [XL-1:0]  alu_b   [2];
   logic [OPW-1:0] alu_op  [2];
   logic [XL-1:0]  alu_out [2];
   logic           alu_cmp [2];
   logic [31:0]    cnt     [2];

   function automatic logic [XL-1:0] alu_res(input logic [OPW-1:0] op,
                                             input logic [XL-1:0] a, input logic [XL-1:0] b);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_BLT:  return XL'($signed(a) < $signed(b));
         OP_BLTU: return XL'(a < b);
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         default: return '0;
      endcase
   endfunction

   function automatic logic alu_lt(input logic [OPW-1:0] op,
                                   input logic [XL-1:0] a, input logic [XL-1:0] b);
      case (op)
         OP_BLT:  return $signed(a) < $signed(b);
         OP_BLTU: return a < b;
         default: return a == b;
      endcase
   endfunction

   // Instance 0 is round-robin, instance 1 is fixed priority
   for (genvar m = 0; m < 2; m++) begin : g_dut
      alu_arbiter #(.RR_EN(m == 0 ? 1 : 0)) dut (
         .clk(clk), .rst(rst), .flush_i(flush),
         .r0_valid_i(vld[0]), .r0_ready_o(rdy[m][0]), .r0_a_i(opa[0]), .r0_b_i(opb[0]),
         .r0_op_i(opc[0]), .r0_tag_i(tgi[0]), .r0_res_valid_o(rvld[m][0]),
         .r0_res_ready_i(rrdy[0]), .r0_res_o(res[m][0]), .r0_cmp_o(cmpo[m][0]),
         .r0_tag_o(tgo[m][0]),
         .r1_valid_i(vld[1]), .r1_ready_o(rdy[m][1]), .r1_a_i(opa[1]), .r1_b_i(opb[1]),
         .r1_op_i(opc[1]), .r1_tag_i(tgi[1]), .r1_res_valid_o(rvld[m][1]),
         .r1_res_ready_i(rrdy[1]), .r1_res_o(res[m][1]), .r1_cmp_o(cmpo[m][1]),
         .r1_tag_o(tgo[m][1]),
         .alu_a_o(alu_a[m]), .alu_b_o(alu_b[m]), .alu_op_o(alu_op[m]),
         .alu_out_i(alu_out[m]), .alu_cmp_i(alu_cmp[m]),
         .conflict_cnt_o(cnt[m])
      );
      assign alu_out[m] = alu_res(alu_op[m], alu_a[m], alu_b[m]);
      assign alu_cmp[m] = alu_lt(alu_op[m], alu_a[m], alu_b[m]);
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic                 s1v;
      logic                 own;
      logic [XL-1:0]        a;
      logic [XL-1:0]        b;
      logic [OPW-1:0]       op;
      logic [3:0]           tag;
      logic [1:0]           rbv;
      logic [1:0][XL-1:0]   rbres;
      logic [1:0]           rbcmp;
      logic [1:0][3:0]      rbtag;
      logic                 last;
      logic [31:0]          cnt;
   } mstate_t;

   mstate_t ms [2];
   mstate_t nx [2];
   logic    obs_rdy [2][2];
   logic [3:0] gseq [2];
   int      checks;
   int      errors;

   function automatic mstate_t resetState();
      mstate_t s;
      s      = '0;
      s.last = 1'b1;
      return s;
   endfunction

   task automatic expect64(input string name, input int m, input logic [63:0] got,
                           input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s inst=%0d got=%h expected=%h at %0t", name, m, got, exp, $time);
      end
   endtask

   task automatic setReq(input int r, input logic v, input logic [XL-1:0] a,
                         input logic [XL-1:0] b, input logic [OPW-1:0] op, input logic [3:0] tag);
      vld[r] = v;
      opa[r] = a;
      opb[r] = b;
      opc[r] = op;
      tgi[r] = tag;
   endtask

   // Compares every DUT output with the model, then computes the model's state after the next edge
   task automatic checkOutput();
      for (int m = 0; m < 2; m++) begin
         mstate_t    st;
         mstate_t    n;
         logic [1:0] pop;
         logic       drain;
         logic       can;
         int         g;
         if (rst) ms[m] = resetState();
         st    = ms[m];
         pop   = st.rbv & {rrdy[1], rrdy[0]};
         drain = st.s1v && (!st.rbv[st.own] || pop[st.own]);
         can   = (!st.s1v || drain) && !flush && !rst;
         g = -1;
         if (vld[0] && vld[1]) g = (m == 0) ? (st.last ? 0 : 1) : 0;
         else if (vld[0])      g = 0;
         else if (vld[1])      g = 1;
         for (int r = 0; r < 2; r++) begin
            obs_rdy[m][r] = rdy[m][r];
            expect64($sformatf("r%0d_ready", r), m, 64'(rdy[m][r]), 64'(can && g == r));
            expect64($sformatf("r%0d_res_valid", r), m, 64'(rvld[m][r]), 64'(st.rbv[r]));
            if (st.rbv[r]) begin
               expect64($sformatf("r%0d_res", r), m, 64'(res[m][r]), 64'(st.rbres[r]));
               expect64($sformatf("r%0d_cmp", r), m, 64'(cmpo[m][r]), 64'(st.rbcmp[r]));
               expect64($sformatf("r%0d_tag", r), m, 64'(tgo[m][r]), 64'(st.rbtag[r]));
            end
         end
         expect64("alu_a", m, 64'(alu_a[m]), st.s1v ? 64'(st.a) : 64'd0);
         expect64("alu_b", m, 64'(alu_b[m]), st.s1v ? 64'(st.b) : 64'd0);
         expect64("alu_op", m, 64'(alu_op[m]), st.s1v ? 64'(st.op) : 64'd0);
         expect64("conflict_cnt", m, 64'(cnt[m]), 64'(st.cnt));

         n = st;
         if (rst) begin
            n = resetState();
         end else begin
            if (flush) begin
               n.s1v = 1'b0;
               n.rbv = 2'b00;
            end else begin
               n.rbv = st.rbv & ~pop;
               if (drain) begin
                  n.rbv[st.own]   = 1'b1;
                  n.rbres[st.own] = alu_res(st.op, st.a, st.b);
                  n.rbcmp[st.own] = alu_lt(st.op, st.a, st.b);
                  n.rbtag[st.own] = st.tag;
                  n.s1v           = 1'b0;
               end
               if (can && g >= 0) begin
                  n.s1v  = 1'b1;
                  n.own  = g[0];
                  n.a    = opa[g];
                  n.b    = opb[g];
                  n.op   = opc[g];
                  n.tag  = tgi[g];
                  n.last = g[0];
               end
            end
            if (vld[0] && vld[1] && st.cnt != 32'hFFFF_FFFF) n.cnt = st.cnt + 32'd1;
         end
         nx[m] = n;
      end
   endtask

   task automatic runCycle();
      #1;
      checkOutput();
      @(posedge clk);
      for (int m = 0; m < 2; m++) ms[m] = nx[m];
      @(negedge clk);
   endtask

   task automatic applyStimulus();
      rst   = ($urandom_range(0, 399) == 0);
      flush = ($urandom_range(0, 39) == 0);
      for (int r = 0; r < 2; r++) begin
         setReq(r, $urandom_range(0, 9) < 6,
                ($urandom_range(0, 3) == 0) ? XL'($urandom_range(0, 15)) : {$urandom, $urandom},
                ($urandom_range(0, 3) == 0) ? XL'($urandom_range(0, 15)) : {$urandom, $urandom},
                OPW'($urandom_range(0, 6)), 4'($urandom_range(0, 15)));
         rrdy[r] = ($urandom_range(0, 9) < 7);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      flush  = 1'b0;
      for (int r = 0; r < 2; r++) begin
         setReq(r, 1'b0, '0, '0, OP_ADD, 4'd0);
         rrdy[r] = 1'b1;
      end
      for (int m = 0; m < 2; m++) ms[m] = resetState();
      @(negedge clk);

      // Reset holds readies low even with a request pending
      setReq(0, 1'b1, 64'd1, 64'd2, OP_ADD, 4'd1);
      runCycle();
      runCycle();
      for (int m = 0; m < 2; m++) begin
         expect64("reset_ready", m, 64'(obs_rdy[m][0]), 64'd0);
         expect64("reset_cnt", m, 64'(cnt[m]), 64'd0);
         expect64("reset_res_valid", m, 64'(rvld[m][0]), 64'd0);
      end
      rst = 1'b0;
      setReq(0, 1'b0, '0, '0, OP_ADD, 4'd0);
      runCycle();

      // Four cycles of conflict
      for (int k = 0; k < 4; k++) begin
         setReq(0, 1'b1, XL'(k), XL'(1), OP_ADD, 4'(k));
         setReq(1, 1'b1, XL'(k), XL'(2), OP_SUB, 4'(k + 8));
         runCycle();
         for (int m = 0; m < 2; m++) gseq[m][k] = obs_rdy[m][1];
      end
      expect64("rr_grant_seq", 0, 64'(gseq[0]), 64'(4'b1010));
      expect64("fp_grant_seq", 1, 64'(gseq[1]), 64'(4'b0000));
      for (int m = 0; m < 2; m++) expect64("conflict_cnt4", m, 64'(cnt[m]), 64'd4);
      setReq(0, 1'b0, '0, '0, OP_ADD, 4'd0);
      setReq(1, 1'b0, '0, '0, OP_ADD, 4'd0);
      repeat (3) runCycle();

      // Single ADD latency
      setReq(0, 1'b1, 64'd5, 64'd3, OP_ADD, 4'd2);
      runCycle();
      for (int m = 0; m < 2; m++) expect64("add_alu_a", m, 64'(alu_a[m]), 64'd5);
      setReq(0, 1'b0, '0, '0, OP_ADD, 4'd0);
      runCycle();
      for (int m = 0; m < 2; m++) begin
         expect64("add_res_valid", m, 64'(rvld[m][0]), 64'd1);
         expect64("add_res", m, 64'(res[m][0]), 64'd8);
         expect64("add_tag", m, 64'(tgo[m][0]), 64'd2);
      end
      runCycle();

      // Back-pressure on RB1 stalls S1 and both requesters
      rrdy[1] = 1'b0;
      setReq(1, 1'b1, 64'd1, 64'd1, OP_ADD, 4'd1);
      runCycle();
      setReq(1, 1'b1, 64'd10, 64'd4, OP_SUB, 4'd3);
      runCycle();
      setReq(1, 1'b0, '0, '0, OP_ADD, 4'd0);
      setReq(0, 1'b1, 64'd7, 64'd7, OP_ADD, 4'd5);
      for (int k = 0; k < 3; k++) begin
         runCycle();
         for (int m = 0; m < 2; m++) begin
            expect64("stall_alu_a", m, 64'(alu_a[m]), 64'd10);
            expect64("stall_alu_b", m, 64'(alu_b[m]), 64'd4);
            expect64("stall_ready0", m, 64'(obs_rdy[m][0]), 64'd0);
            expect64("stall_rb1_res", m, 64'(res[m][1]), 64'd2);
         end
      end
      setReq(0, 1'b0, '0, '0, OP_ADD, 4'd0);
      rrdy[1] = 1'b1;
      runCycle();
      for (int m = 0; m < 2; m++) begin
         expect64("sub_res_valid", m, 64'(rvld[m][1]), 64'd1);
         expect64("sub_res", m, 64'(res[m][1]), 64'd6);
         expect64("sub_tag", m, 64'(tgo[m][1]), 64'd3);
      end
      runCycle();

      // Signed versus unsigned compare
      setReq(0, 1'b1, {XL{1'b1}}, 64'd1, OP_BLT, 4'd6);
      runCycle();
      setReq(0, 1'b1, {XL{1'b1}}, 64'd1, OP_BLTU, 4'd7);
      runCycle();
      for (int m = 0; m < 2; m++) begin
         expect64("blt_cmp", m, 64'(cmpo[m][0]), 64'd1);
         expect64("blt_res", m, 64'(res[m][0]), 64'd1);
      end
      setReq(0, 1'b0, '0, '0, OP_ADD, 4'd0);
      runCycle();
      for (int m = 0; m < 2; m++) begin
         expect64("bltu_cmp", m, 64'(cmpo[m][0]), 64'd0);
         expect64("bltu_res", m, 64'(res[m][0]), 64'd0);
      end
      runCycle();

      // Flush with S1 and RB0 both occupied
      rrdy[0] = 1'b0;
      setReq(0, 1'b1, 64'd7, 64'd7, OP_ADD, 4'd8);
      runCycle();
      setReq(0, 1'b1, 64'd1, 64'd1, OP_ADD, 4'd9);
      runCycle();
      setReq(0, 1'b0, '0, '0, OP_ADD, 4'd0);
      for (int m = 0; m < 2; m++) begin
         expect64("preflush_rb0", m, 64'(rvld[m][0]), 64'd1);
         expect64("preflush_alu_a", m, 64'(alu_a[m]), 64'd1);
      end
      flush = 1'b1;
      runCycle();
      flush = 1'b0;
      rrdy[0] = 1'b1;
      for (int m = 0; m < 2; m++) begin
         expect64("flush_rb0", m, 64'(rvld[m][0]), 64'd0);
         expect64("flush_alu_a", m, 64'(alu_a[m]), 64'd0);
      end
      runCycle();
      setReq(0, 1'b1, 64'd2, 64'd2, OP_OR, 4'd1);
      setReq(1, 1'b1, 64'd3, 64'd3, OP_OR, 4'd2);
      runCycle();
      expect64("postflush_rr_grant1", 0, 64'(obs_rdy[0][1]), 64'd1);
      expect64("postflush_fp_grant0", 1, 64'(obs_rdy[1][0]), 64'd1);
      setReq(0, 1'b0, '0, '0, OP_ADD, 4'd0);
      setReq(1, 1'b0, '0, '0, OP_ADD, 4'd0);
      repeat (3) runCycle();

      // Asynchronous reset between edges with S1 occupied
      setReq(0, 1'b1, 64'd9, 64'd9, OP_XOR, 4'd10);
      runCycle();
      setReq(0, 1'b0, '0, '0, OP_ADD, 4'd0);
      #2;
      rst = 1'b1;
      #1;
      for (int m = 0; m < 2; m++) begin
         expect64("async_rst_alu_a", m, 64'(alu_a[m]), 64'd0);
         expect64("async_rst_cnt", m, 64'(cnt[m]), 64'd0);
      end
      runCycle();
      rst = 1'b0;
      setReq(0, 1'b1, 64'd4, 64'd4, OP_AND, 4'd3);
      setReq(1, 1'b1, 64'd5, 64'd5, OP_AND, 4'd4);
      runCycle();
      for (int m = 0; m < 2; m++)
         expect64("post_rst_grant_r0", m, 64'(obs_rdy[m][0]), 64'd1);
      setReq(0, 1'b0, '0, '0, OP_ADD, 4'd0);
      setReq(1, 1'b0, '0, '0, OP_ADD, 4'd0);
      repeat (2) runCycle();

      for (int k = 0; k < 3000; k++) begin
         applyStimulus();
         runCycle();
      end
      rst   = 1'b0;
      flush = 1'b0;
      runCycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter RR_EN, default 1, meaning: 1 = round-robin grant, 0 = fixed priority (requester 0 always wins).
REQ-002 Widths: data width `XLEN (64), op width `ALUOP_LEN, both from the system config; tag width 4.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 flush_i  input  1  synchronous flush of all in-flight work.
REQ-006 rN_valid_i / rN_ready_o (N=0,1)  in/out  1  request handshake per requester.
REQ-007 rN_a_i, rN_b_i  input  `XLEN  operands; rN_op_i  input  `ALUOP_LEN  ALU opcode; rN_tag_i  input  4  requester tag.
REQ-008 rN_res_valid_o / rN_res_ready_i  out/in  1  result handshake per requester.
REQ-009 rN_res_o  output  `XLEN  ALU result; rN_cmp_o  output  1  compare result; rN_tag_o  output  4  echoed tag.
REQ-010 alu_a_o, alu_b_o  output  `XLEN; alu_op_o  output  `ALUOP_LEN  drive the shared combinational ALU.
REQ-011 alu_out_i  input  `XLEN; alu_cmp_i  input  1  ALU result and compare output.
REQ-012 conflict_cnt_o  output  32  count of cycles in which both requests were valid.

Function
REQ-013 The block SHALL hold one issue stage (S1: valid, owner, a, b, op, tag) and one result buffer per requester (RB0, RB1: valid, res, cmp, tag).
REQ-014 alu_a_o/alu_b_o/alu_op_o SHALL be driven from S1 registers when S1 is valid, and SHALL be all-zero otherwise.
REQ-015 S1 drains at a rising edge when S1 is valid and RB[owner] is empty or popped (rN_res_valid_o & rN_res_ready_i) in that cycle; on drain, alu_out_i/alu_cmp_i/S1.tag are written into RB[owner].
REQ-016 S1 can accept when S1 is empty or draining in the same cycle, and flush_i is low.
REQ-017 rN_ready_o SHALL be high only when S1 can accept and requester N holds the grant; the ready signals SHALL never be high together.
REQ-018 Grant: if only one rN_valid_i is high, that requester is granted; if both are high, with RR_EN=1 the requester other than last_grant is granted, and with RR_EN=0 requester 0 is granted.
REQ-019 last_grant SHALL update to the accepted requester only on an accept (valid & ready).
REQ-020 Latency: a request accepted at edge E0 SHALL appear in RB at edge E1 if not stalled, so rN_res_valid_o rises one cycle after the accept; sustained throughput is 1 op/cycle.
REQ-021 Back-pressure: a full, unpopped RB[owner] SHALL stall S1, which blocks both requesters (head-of-line); the S1 contents and ALU drive SHALL stay stable while stalled.
REQ-022 rN_res_o/cmp/tag SHALL stay stable while rN_res_valid_o is high and rN_res_ready_i is low.
REQ-023 flush_i high at an edge SHALL clear S1.valid, RB0.valid and RB1.valid, and accepts nothing in that cycle; it SHALL NOT change last_grant or conflict_cnt_o.
REQ-024 conflict_cnt_o SHALL increment by 1 at each edge where r0_valid_i & r1_valid_i, saturating at 0xFFFF_FFFF.
REQ-025 Results SHALL be returned in per-requester acceptance order; there is no reordering.

Reset
REQ-026 While rst is high (asynchronously): S1.valid=0, RB0/RB1.valid=0, all data registers=0, last_grant=1 (requester 0 wins the first conflict), conflict_cnt_o=0.
REQ-027 Outputs during reset: rN_ready_o=0, rN_res_valid_o=0, alu_* outputs=0.
REQ-028 rst asserted mid-operation SHALL discard in-flight S1/RB contents with no result delivered.

Verification
REQ-029 r0 only: a=5, b=3, op=ADD, tag=2, accepted at E0 -> r0_res_valid_o=1 after E1 with res=8, tag=2.
REQ-030 Both valid for 4 cycles, RR_EN=1, RB readies held high -> grants 0,1,0,1 in order; conflict_cnt_o=4.
REQ-031 r1_res_ready_i=0 with RB1 full, r1 issues SUB 10-4 into S1 -> S1 holds, alu_a_o=10 and alu_b_o=4 stable, both readies low; when ready rises, res=6 is delivered next cycle.
REQ-032 BLT a=-1, b=1 -> cmp=1, res=1; BLTU with the same operands -> cmp=0.
REQ-033 flush_i pulsed with S1 and RB0 valid -> all valids 0 on the next cycle, no result delivered, last_grant unchanged.
REQ-034 rst pulsed asynchronously between edges with S1 valid -> outputs reset immediately; the first conflict after release is granted to r0.
